// File: rtl/img_frame_streamer.sv
// Raster-order pixel source: streams one frame from a synchronous RAM, inserts
// row blanking, appends zero flush pixels and pulses frame_done. Optional build
// macro STREAMER_TEST_PATTERN_EN replaces RAM data with the raster index.
module img_frame_streamer #(
    parameter int WIDTH        = 512,
    parameter int DEPTH        = 640,
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 20,
    parameter int HBLANK       = 2,
    parameter int FLUSH_PIXELS = 2*WIDTH+3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  frame_abort,
    input  logic                  sink_ready,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  start,
    output logic                  data_en,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
    localparam int FW = (FLUSH_PIXELS > 1) ? $clog2(FLUSH_PIXELS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_HBLANK,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [HW-1:0]         hcnt;
    logic [FW-1:0]         fcnt;
    logic [ADDR_WIDTH-1:0] addr;

    logic issue, row_end, last_row, hblank_end, flush_end, drained;
    logic rd_strobe;
    logic vld_p0, vld_p1, flush_p0;
    logic [DATA_WIDTH-1:0] pix_src, pix_p1;

    assign issue      = sink_ready && (state == S_STREAM || state == S_FLUSH);
    assign row_end    = issue && (state == S_STREAM) && (col == CW'(WIDTH-1));
    assign last_row   = (row == RW'(DEPTH-1));
    assign hblank_end = (state == S_HBLANK) && (hcnt == HW'(HBLANK-1));
    assign flush_end  = issue && (state == S_FLUSH) && (fcnt == FW'(FLUSH_PIXELS-1));
    // Only the final pixel is left once the issue stage has emptied in DRAIN.
    assign drained    = (state == S_DRAIN) && vld_p1 && !vld_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (row_end) begin
                    if (last_row) begin
                        if (FLUSH_PIXELS == 0) state_nxt = S_DRAIN;
                        else                   state_nxt = S_FLUSH;
                    end else if (HBLANK != 0) begin
                        state_nxt = S_HBLANK;
                    end
                end
            end
            S_HBLANK: begin
                if (hblank_end) state_nxt = S_STREAM;
            end
            S_FLUSH: begin
                if (flush_end) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (drained) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (frame_abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            hcnt <= '0;
            fcnt <= '0;
            addr <= '0;
        end else if (state == S_IDLE) begin
            if (frame_start) begin
                col  <= '0;
                row  <= '0;
                hcnt <= '0;
                fcnt <= '0;
                addr <= '0;
            end
        end else begin
            if (issue && state == S_STREAM) begin
                addr <= addr + 1'b1;
                if (row_end) begin
                    col <= '0;
                    if (!last_row) row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (state == S_HBLANK) begin
                hcnt <= hblank_end ? '0 : hcnt + 1'b1;
            end
            if (issue && state == S_FLUSH) begin
                fcnt <= fcnt + 1'b1;
            end
        end
    end

`ifdef STREAMER_TEST_PATTERN_EN
    logic [DATA_WIDTH-1:0] pat_p0;
    logic                  unused_rd;

    assign unused_rd = ^mem_rd_data;
    assign rd_strobe = 1'b0;
    assign pix_src   = pat_p0;

    // The linear address equals row*WIDTH+col at every issue.
    always_ff @(posedge clk) begin
        pat_p0 <= DATA_WIDTH'(addr);
    end
`else
    assign rd_strobe = issue && (state == S_STREAM);
    assign pix_src   = mem_rd_data;
`endif

    // Stage p0: issue registered, RAM read in flight.
    always_ff @(posedge clk) begin
        if (rst || frame_abort) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= issue;
            vld_p1 <= vld_p0;
        end
    end

    // Stage p1: pixel captured, zero for flush issues.
    always_ff @(posedge clk) begin
        flush_p0 <= (state == S_FLUSH);
        pix_p1   <= flush_p0 ? '0 : pix_src;
    end

    assign mem_rd_en  = rd_strobe;
    assign mem_addr   = addr;
    assign start      = (state != S_IDLE);
    assign busy       = (state != S_IDLE);
    assign data_en    = vld_p1;
    assign pixel_out  = vld_p1 ? pix_p1 : '0;
    assign frame_done = drained && !frame_abort;

endmodule

// File: tb/tb_img_frame_streamer.sv
// Randomised/directed bench for img_frame_streamer with a queue-based model of
// the expected pixel stream, address sequence and frame_done timing.
module tb_img_frame_streamer;

    localparam int W     = 4;
    localparam int D     = 3;
    localparam int HB    = 2;
    localparam int FL    = 11;
    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int NPIX  = W*D;
    localparam int TOTAL = NPIX + FL;
`ifdef STREAMER_TEST_PATTERN_EN
    localparam int PIX0 = 0;
    localparam int NRD  = 0;
`else
    localparam int PIX0 = 100;
    localparam int NRD  = NPIX;
`endif

    logic          clk = 1'b0;
    logic          rst, frame_start, frame_abort, sink_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          start, data_en, busy, frame_done;
    logic [DW-1:0] pixel_out;

    img_frame_streamer #(
        .WIDTH(W), .DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .HBLANK(HB), .FLUSH_PIXELS(FL)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .frame_abort(frame_abort),
        .sink_ready(sink_ready), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data), .start(start), .data_en(data_en),
        .pixel_out(pixel_out), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'(i + 100);
        mem_rd_data = '0;
    end
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= ram[mem_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q [$];
    bit            exp_busy = 0;
    int            cnt = 0;
    int            exp_addr = 0;
    int            n_rd = 0;
    int            n_done = 0;
    int            start_cyc = 0;
    int            last_iss = 0;
    bit            sr1 = 0, sr2 = 0;
    bit            gap_chk = 0;
    bit            chk_zero = 0;
    bit            done_now;
    logic [DW-1:0] pv;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        done_now = 0;
        if (chk_zero) begin
            chk("zero_start", start, 0);
            chk("zero_busy", busy, 0);
            chk("zero_data_en", data_en, 0);
            chk("zero_pixel", pixel_out, 0);
            chk("zero_rd_en", mem_rd_en, 0);
            chk("zero_addr", mem_addr, 0);
            chk("zero_done", frame_done, 0);
        end
        chk("busy", busy, exp_busy);
        chk("start", start, exp_busy);
        if (data_en) begin
            if (exp_q.size() == 0) begin
                chk("data_en_unexpected", 1, 0);
            end else begin
                pv = exp_q.pop_front();
                if (cnt == 0) chk("first_pixel", pixel_out, PIX0);
                chk("pixel", pixel_out, pv);
                chk("issue_ready", sr2, 1);
                cnt++;
                if (cnt == 1 && gap_chk) chk("first_latency", cyc - start_cyc, 3);
                chk("frame_done_at_last", frame_done, (cnt == TOTAL) ? 1 : 0);
                if (cnt == TOTAL) begin
                    done_now = 1;
                    n_done++;
                    chk("mem_reads", n_rd, NRD);
                    if (gap_chk) chk("done_latency", cyc - start_cyc, 29);
                end
            end
        end else begin
            chk("idle_pixel", pixel_out, 0);
            chk("frame_done_idle", frame_done, 0);
        end
`ifdef STREAMER_TEST_PATTERN_EN
        chk("no_rd_en", mem_rd_en, 0);
`endif
        if (mem_rd_en) begin
            chk("rd_ready", sink_ready, 1);
            chk("rd_addr", mem_addr, exp_addr);
            if (gap_chk) begin
                if (exp_addr == 0) chk("rd_gap0", cyc - start_cyc, 1);
                else chk("rd_gap", cyc - last_iss, (exp_addr == 4 || exp_addr == 8) ? 3 : 1);
            end
            last_iss = cyc;
            exp_addr++;
            n_rd++;
        end
        // Advance the model using the inputs the DUT samples at the next edge.
        if (rst || frame_abort) begin
            exp_busy = 0;
            exp_q.delete();
        end else if (!exp_busy && frame_start) begin
            exp_busy  = 1;
            start_cyc = cyc;
            cnt       = 0;
            exp_addr  = 0;
            n_rd      = 0;
            exp_q.delete();
            for (int i = 0; i < NPIX; i++) exp_q.push_back(16'(i + PIX0));
            for (int i = 0; i < FL; i++) exp_q.push_back('0);
        end else if (done_now) begin
            exp_busy = 0;
        end
        sr2 = sr1;
        sr1 = sink_ready;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
    endtask

    task automatic wait_cnt(input int target);
        int k = 0;
        while (cnt < target && k < 300) begin
            step(1);
            k++;
        end
        if (cnt < target) begin
            $display("FAIL pixel_count_timeout: got %0d expected %0d", cnt, target);
            $fatal(1, "timeout");
        end
    endtask

    task automatic wait_done(input int prev);
        int k = 0;
        while (n_done == prev && k < 300) begin
            step(1);
            k++;
        end
        if (n_done == prev) begin
            $display("FAIL frame_done_timeout: got %0d expected %0d", n_done, prev + 1);
            $fatal(1, "timeout");
        end
    endtask

    initial begin
        int prev;
        rst = 1'b1; frame_start = 1'b0; frame_abort = 1'b0; sink_ready = 1'b1;
        chk_zero = 1'b1;
        step(3);
        rst = 1'b0;
        step(1);
        chk_zero = 1'b0;
        step(2);

        // Plain frame with literal timing checks
        gap_chk = 1'b1;
        prev = n_done;
        pulse_start();
        wait_done(prev);
        step(3);
        gap_chk = 1'b0;

        // Backpressure mid row 1 and during flush
        prev = n_done;
        pulse_start();
        wait_cnt(5);
        sink_ready = 1'b0;
        step(3);
        sink_ready = 1'b1;
        wait_cnt(15);
        sink_ready = 1'b0;
        step(1);
        sink_ready = 1'b1;
        wait_done(prev);
        step(3);

        // Abort after the 6th pixel, then restart
        pulse_start();
        wait_cnt(6);
        frame_abort = 1'b1;
        step(1);
        frame_abort = 1'b0;
        step(6);
        prev = n_done;
        pulse_start();
        wait_done(prev);
        step(3);

        // frame_start while busy is ignored
        prev = n_done;
        pulse_start();
        step(5);
        pulse_start();
        wait_done(prev);
        step(6);

        // Reset in the middle of FLUSH
        pulse_start();
        wait_cnt(14);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk_zero = 1'b1;
        step(1);
        chk_zero = 1'b0;
        step(5);

        // Random backpressure frames
        for (int f = 0; f < 3; f++) begin
            int k;
            prev = n_done;
            pulse_start();
            k = 0;
            while (n_done == prev && k < 400) begin
                sink_ready = ($urandom_range(0, 3) != 0);
                step(1);
                k++;
            end
            sink_ready = 1'b1;
            if (n_done == prev) begin
                $display("FAIL random_frame_timeout: got %0d expected %0d", n_done, prev + 1);
                $fatal(1, "timeout");
            end
            step(3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/img_frame_streamer.md
Name: img_frame_streamer

Overview:
- Raster-order pixel source for the 3x3 window generators: reads one image from a synchronous frame RAM and drives start / data_en / pixel into the line-buffer stage.
- Inserts a programmable horizontal blank after each row.
- After the last pixel, appends zero-valued flush pixels so the window pipeline drains its final rows.
- Pulses frame_done once the last flush pixel has been presented.

Parameters:
- WIDTH, 512: pixels per row (column count).
- DEPTH, 640: rows per frame.
- DATA_WIDTH, 16: pixel width.
- ADDR_WIDTH, 20: frame RAM address width; must satisfy 2^ADDR_WIDTH >= WIDTH*DEPTH.
- HBLANK, 2: idle cycles inserted after each row except the last; 0 is legal.
- FLUSH_PIXELS, 2*WIDTH+3: zero pixels appended after the last real pixel.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous active-high reset.
- frame_start, in, 1: one-cycle request to stream a frame; honoured only in IDLE.
- frame_abort, in, 1: cancels the frame in progress.
- sink_ready, in, 1: downstream may accept pixels; one-cycle accept latency (see Behaviour).
- mem_rd_en, out, 1: frame RAM read strobe.
- mem_addr, out, ADDR_WIDTH: frame RAM read address, linear raster index.
- mem_rd_data, in, DATA_WIDTH: RAM read data, valid 1 cycle after mem_rd_en.
- start, out, 1: frame active; high from the STREAM-entry cycle through the frame_done cycle.
- data_en, out, 1: pixel valid strobe to the window generator.
- pixel_out, out, DATA_WIDTH: pixel value; 0 during flush pixels and when data_en=0.
- busy, out, 1: state != IDLE.
- frame_done, out, 1: one-cycle pulse at frame completion.

Behaviour:
- Reset: all outputs 0 and state IDLE.
  - Reset applies on the next clk edge, including mid-frame; in-flight pixels are discarded and frame_done does not pulse.
- States: IDLE, STREAM, HBLANK, FLUSH, DRAIN.
- IDLE:
  - frame_start=1 -> STREAM on the next cycle; row=0, col=0, addr=0.
  - frame_start during any other state is ignored.
- Issue slot:
  - In STREAM or FLUSH, a cycle with sink_ready=1 is an issue. Otherwise the state holds and no counter moves.
  - A STREAM issue drives mem_rd_en=1 with mem_addr=current addr, then addr+1 and col+1.
  - A FLUSH issue drives mem_rd_en=0 and increments the flush counter.
- Output pipeline, 2 cycles:
  - An issue at cycle T produces data_en=1 at T+2.
  - pixel_out at T+2 is mem_rd_data registered at T+1, or 0 for a flush issue.
  - Downstream must accept every pixel issued while sink_ready was high; dropping sink_ready stops new issues only.
- Row end: an issue with col=WIDTH-1 sets col=0.
  - If row<DEPTH-1: row+1, then HBLANK (or directly STREAM if HBLANK=0).
  - If row=DEPTH-1: FLUSH, or DRAIN if FLUSH_PIXELS=0.
- HBLANK: counts exactly HBLANK cycles, ignoring sink_ready, then -> STREAM. No issues occur during HBLANK.
- FLUSH: after FLUSH_PIXELS issues -> DRAIN.
- DRAIN: waits until the pipeline is empty.
  - frame_done=1 is asserted in the same cycle as the final data_en.
  - start drops on the cycle after that; state -> IDLE.
- Addressing: mem_addr is a linear counter that never wraps within a frame. The last read address is WIDTH*DEPTH-1.
- frame_abort: from any non-IDLE state -> IDLE on the next cycle.
  - Pipeline stages are cleared, so no data_en is asserted after the abort edge.
  - start and busy drop; frame_done does not pulse.
  - Abort takes priority over a simultaneous row end or flush end.
  - frame_start together with abort in a non-IDLE state is ignored.
- Frame totals: data_en pulses per frame = WIDTH*DEPTH+FLUSH_PIXELS exactly; mem_rd_en pulses = WIDTH*DEPTH.

Optional Feature:
- Macro: STREAMER_TEST_PATTERN_EN.
- Defined:
  - mem_rd_en is held 0.
  - Real pixels carry the test pattern (row*WIDTH+col) truncated to DATA_WIDTH, taken from the counters at issue and delayed 2 cycles.
  - mem_rd_data is ignored.
  - Timing, flush and frame_done are identical to the normal build.
- Undefined: pixels come from mem_rd_data as described above.

Test Plan:
- Bench configuration for all scenarios: WIDTH=4, DEPTH=3, HBLANK=2, FLUSH_PIXELS=11; RAM preloaded with word i = i+100.
- Frame with sink_ready held 1, frame_start pulsed at cycle 0:
  - mem_addr runs 0..11 with 2 idle cycles after addresses 3 and 7.
  - data_en has 12 real pulses carrying pixel_out 100..111, then 11 pulses of 0.
  - frame_done is a single pulse coincident with the 23rd data_en; start drops the cycle after.
- Backpressure: sink_ready low for 3 cycles mid-row 1, and low for 1 cycle during FLUSH:
  - Pixel order and values are unchanged; total data_en pulses = 23.
  - No issues occur while sink_ready is low; at most 2 pixels arrive after sink_ready falls.
- Abort after the 6th data_en:
  - No data_en from the cycle after the abort edge; busy=0 and no frame_done.
  - A subsequent frame_start restarts at mem_addr 0 with pixel 100.
- frame_start pulsed while busy: ignored; frame completes with exactly 23 data_en and a single frame_done.
- rst asserted mid-FLUSH for 1 cycle: all outputs 0 on the next cycle, state IDLE, no frame_done.
- STREAMER_TEST_PATTERN_EN defined, sink_ready held 1: pixel_out sequence 0..11 then 11 zeros; mem_rd_en never asserted.
